// File: rtl/ofs_plat_host_chan_tx_tlp_arb_pkg.sv
// Shared types and constants for the host-channel TX TLP arbiter.
// Optional statistics are enabled by OFS_PLAT_TX_TLP_ARB_STATS_EN.
package ofs_plat_host_chan_tx_arb_pkg;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } t_arb_mode;

   typedef enum logic {
      ST_OPEN   = 1'b0,
      ST_LOCKED = 1'b1
   } t_lock_state;

   localparam int STATS_CNT_W = 32;
   localparam int STATS_MAX_W = 16;

   typedef struct packed {
      logic [STATS_CNT_W-1:0] pkts;
      logic [STATS_CNT_W-1:0] waits;
   } t_arb_stats;

   function automatic logic [STATS_CNT_W-1:0] sat_inc_cnt(input logic [STATS_CNT_W-1:0] v);
      return (v == '1) ? v : v + STATS_CNT_W'(1);
   endfunction

   function automatic logic [STATS_MAX_W-1:0] sat_inc_max(input logic [STATS_MAX_W-1:0] v);
      return (v == '1) ? v : v + STATS_MAX_W'(1);
   endfunction

endpackage

// File: rtl/ofs_plat_host_chan_tx_tlp_arb_if.sv
// N source TX TLP streams plus the merged output stream.
// slave = arbiter side, master = sources and downstream sink.
interface ofs_plat_host_chan_tx_tlp_arb_if #(
   parameter int NUM_SRC = 3,
   parameter int BEAT_W  = 512
);
   localparam int IDX_W = $clog2(NUM_SRC);

   logic [NUM_SRC-1:0]        src_tvalid;
   logic [NUM_SRC-1:0]        src_tready;
   logic [NUM_SRC*BEAT_W-1:0] src_tdata;
   logic [NUM_SRC-1:0]        src_tlast;
   logic                      out_tvalid;
   logic                      out_tready;
   logic [BEAT_W-1:0]         out_tdata;
   logic                      out_tlast;
   logic [IDX_W-1:0]          out_src;

   modport master (
      output src_tvalid, src_tdata, src_tlast, out_tready,
      input  src_tready, out_tvalid, out_tdata, out_tlast, out_src
   );

   modport slave (
      input  src_tvalid, src_tdata, src_tlast, out_tready,
      output src_tready, out_tvalid, out_tdata, out_tlast, out_src
   );
endinterface

// File: rtl/ofs_plat_host_chan_tx_tlp_arb_rr_pick.sv
// Combinational rotate / lowest-set-bit / unrotate picker; ptr=0 gives fixed priority.
module ofs_plat_prim_rr_pick #(
   parameter int N = 3
)(
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         grant_o
);
   localparam int IW = $clog2(N);

   logic [N-1:0]  req_rot;
   logic [N-1:0]  gnt_rot;
   logic [IW-1:0] idx;

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      req_rot = '0;
      grant_o = '0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         idx        = IW'((k + int'(ptr_i)) % N);
         req_rot[k] = req_i[idx];
      end
      gnt_rot = req_rot & (~req_rot + N'(1));
      for (int k = 0; k < N; k++) begin
         idx          = IW'((k + int'(ptr_i)) % N);
         grant_o[idx] = gnt_rot[k];
      end
   end
endmodule

// File: rtl/ofs_plat_host_chan_tx_tlp_arb.sv
// N-source packet-atomic TX TLP arbiter, fixed or round-robin, optional output skid.
// Define OFS_PLAT_TX_TLP_ARB_STATS_EN to add per-source stats_o / max_wait_o.
module ofs_plat_host_chan_tx_tlp_arb
   import ofs_plat_host_chan_tx_arb_pkg::*;
#(
   parameter int NUM_SRC  = 3,
   parameter int BEAT_W   = 512,
   parameter int ARB_MODE = 0,
   parameter int OUT_REG  = 1
)(
   input  logic clk,
   input  logic reset_n,
   ofs_plat_host_chan_tx_tlp_arb_if.slave tx
`ifdef OFS_PLAT_TX_TLP_ARB_STATS_EN
   ,
   output logic [NUM_SRC*$bits(t_arb_stats)-1:0] stats_o,
   output logic [NUM_SRC*STATS_MAX_W-1:0]        max_wait_o
`endif
);
   localparam int IDX_W = $clog2(NUM_SRC);
   localparam bit RR_EN = (ARB_MODE == int'(ARB_RR));

   t_lock_state        state_q, state_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [IDX_W-1:0]   pick_ptr, gnt_idx;
   logic [NUM_SRC-1:0] eligible, gnt_oh, src_ready;
   logic               accept_ok, push, push_last;
   logic [BEAT_W-1:0]  push_data;

   // While a packet is open only its owner may be picked.
   always_comb begin
      eligible = tx.src_tvalid;
      if (state_q == ST_LOCKED) eligible = tx.src_tvalid & (NUM_SRC'(1) << grant_q);
   end

   assign pick_ptr = RR_EN ? rr_ptr_q : '0;

   ofs_plat_prim_rr_pick #(.N(NUM_SRC)) u_pick (
      .req_i   (eligible),
      .ptr_i   (pick_ptr),
      .grant_o (gnt_oh)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_SRC; i++)
         if (gnt_oh[i]) gnt_idx = IDX_W'(i);
   end

   assign src_ready     = reset_n ? (gnt_oh & {NUM_SRC{accept_ok}}) : '0;
   assign tx.src_tready = src_ready;
   assign push          = |src_ready;
   assign push_last     = tx.src_tlast[gnt_idx];
   assign push_data     = tx.src_tdata[gnt_idx*BEAT_W +: BEAT_W];

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      rr_ptr_d = rr_ptr_q;
      if (push) begin
         if (push_last) begin
            state_d  = ST_OPEN;
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_SRC-1)) ? '0 : gnt_idx + IDX_W'(1);
         end else begin
            state_d = ST_LOCKED;
            grant_d = gnt_idx;
         end
      end
   end

   // NOTE: reset is synchronous, so it is tested inside the clocked block, not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q  <= ST_OPEN;
         grant_q  <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   if (OUT_REG != 0) begin : g_skid
      typedef struct packed {
         logic [BEAT_W-1:0] data;
         logic              last;
         logic [IDX_W-1:0]  src;
      } t_entry;

      t_entry     mem_q [2];
      logic [1:0] cnt_q;
      logic       wr_q, rd_q, pop;

      assign accept_ok = (cnt_q != 2'd2);
      assign pop       = (cnt_q != 2'd0) && tx.out_tready;

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            cnt_q <= '0;
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
         end else begin
            if (push) wr_q <= ~wr_q;
            if (pop)  rd_q <= ~rd_q;
            if (push && !pop)      cnt_q <= cnt_q + 2'd1;
            else if (pop && !push) cnt_q <= cnt_q - 2'd1;
         end
      end

      // NOTE: payload storage is not reset; cnt_q alone decides whether an entry is meaningful.
      always_ff @(posedge clk) begin
         if (push) mem_q[wr_q] <= {push_data, push_last, gnt_idx};
      end

      assign tx.out_tvalid = reset_n && (cnt_q != 2'd0);
      assign tx.out_tdata  = reset_n ? mem_q[rd_q].data : '0;
      assign tx.out_tlast  = reset_n && mem_q[rd_q].last;
      assign tx.out_src    = reset_n ? mem_q[rd_q].src : '0;
   end else begin : g_comb
      assign accept_ok     = tx.out_tready;
      assign tx.out_tvalid = reset_n && (|gnt_oh);
      assign tx.out_tdata  = reset_n ? push_data : '0;
      assign tx.out_tlast  = reset_n && push_last;
      assign tx.out_src    = reset_n ? gnt_idx : '0;
   end

`ifdef OFS_PLAT_TX_TLP_ARB_STATS_EN
   t_arb_stats             stats_q  [NUM_SRC];
   logic [STATS_MAX_W-1:0] streak_q [NUM_SRC];
   logic [STATS_MAX_W-1:0] max_q    [NUM_SRC];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_SRC; i++) begin
         if (!reset_n) begin
            stats_q[i]  <= '0;
            streak_q[i] <= '0;
            max_q[i]    <= '0;
         end else if (tx.src_tvalid[i] && src_ready[i]) begin
            streak_q[i] <= '0;
            if (tx.src_tlast[i]) stats_q[i].pkts <= sat_inc_cnt(stats_q[i].pkts);
         end else if (tx.src_tvalid[i]) begin
            stats_q[i].waits <= sat_inc_cnt(stats_q[i].waits);
            streak_q[i]      <= sat_inc_max(streak_q[i]);
            if (sat_inc_max(streak_q[i]) > max_q[i]) max_q[i] <= sat_inc_max(streak_q[i]);
         end else begin
            streak_q[i] <= '0;
         end
      end
   end

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_stats_out
      assign stats_o[i*$bits(t_arb_stats) +: $bits(t_arb_stats)] = stats_q[i];
      assign max_wait_o[i*STATS_MAX_W +: STATS_MAX_W]            = max_q[i];
   end
`endif

`ifndef SYNTHESIS
   a_ready_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(tx.src_tready));

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_hold_chk
      a_data_hold: assert property (@(posedge clk) disable iff (!reset_n)
         (tx.src_tvalid[i] && !tx.src_tready[i]) |=> $stable(tx.src_tdata[i*BEAT_W +: BEAT_W]));
   end
`endif
endmodule

// File: tb/tb_ofs_plat_host_chan_tx_tlp_arb.sv
// Directed bench: fixed/comb (dut_a), round-robin/comb (dut_b), fixed/skid (dut_c).
module tb_ofs_plat_host_chan_tx_tlp_arb;
   import ofs_plat_host_chan_tx_arb_pkg::*;

   localparam int N = 3;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   ofs_plat_host_chan_tx_tlp_arb_if #(.NUM_SRC(N), .BEAT_W(W)) ifa ();
   ofs_plat_host_chan_tx_tlp_arb_if #(.NUM_SRC(N), .BEAT_W(W)) ifb ();
   ofs_plat_host_chan_tx_tlp_arb_if #(.NUM_SRC(N), .BEAT_W(W)) ifc ();

`ifdef OFS_PLAT_TX_TLP_ARB_STATS_EN
   logic [N*64-1:0] stats_a, stats_b, stats_c;
   logic [N*16-1:0] maxw_a, maxw_b, maxw_c;
`endif

   ofs_plat_host_chan_tx_tlp_arb #(.NUM_SRC(N), .BEAT_W(W), .ARB_MODE(int'(ARB_FIXED)), .OUT_REG(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .tx(ifa)
`ifdef OFS_PLAT_TX_TLP_ARB_STATS_EN
      , .stats_o(stats_a), .max_wait_o(maxw_a)
`endif
   );

   ofs_plat_host_chan_tx_tlp_arb #(.NUM_SRC(N), .BEAT_W(W), .ARB_MODE(int'(ARB_RR)), .OUT_REG(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .tx(ifb)
`ifdef OFS_PLAT_TX_TLP_ARB_STATS_EN
      , .stats_o(stats_b), .max_wait_o(maxw_b)
`endif
   );

   ofs_plat_host_chan_tx_tlp_arb #(.NUM_SRC(N), .BEAT_W(W), .ARB_MODE(int'(ARB_FIXED)), .OUT_REG(1)) dut_c (
      .clk(clk), .reset_n(reset_n), .tx(ifc)
`ifdef OFS_PLAT_TX_TLP_ARB_STATS_EN
      , .stats_o(stats_c), .max_wait_o(maxw_c)
`endif
   );

   // Hand-derived expectations for the backpressure sequence on dut_c.
   logic bp_otr [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
   logic bp_sv1 [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
   logic bp_rdy [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
   logic bp_ov  [10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   int   bp_od  [10] = '{0, 'hB0, 'hB0, 'hB0, 'hB0, 'hB0, 'hB1, 'hB2, 'hB3, 0};

   int fx_src [5] = '{0, 0, 0, 1, 2};
   int fx_rem [3] = '{3, 1, 1};
   int fx_seq [3] = '{0, 0, 0};
   int rr_src [6] = '{0, 1, 2, 0, 1, 2};
   int bp_k;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state with valids already asserted on dut_a.
      reset_n        = 1'b0;
      ifa.src_tvalid = '1;
      ifa.src_tlast  = '1;
      ifa.src_tdata  = {32'h3, 32'h2, 32'h1};
      ifa.out_tready = 1'b1;
      ifb.src_tvalid = '0; ifb.src_tlast = '0; ifb.src_tdata = '0; ifb.out_tready = 1'b1;
      ifc.src_tvalid = '0; ifc.src_tlast = '0; ifc.src_tdata = '0; ifc.out_tready = 1'b1;
      tick();
      tick();
      check("rst_a_ready", ifa.src_tready, 3'b000);
      check("rst_a_valid", ifa.out_tvalid, 1'b0);
      check("rst_a_src",   ifa.out_src,    2'd0);
      check("rst_a_data",  ifa.out_tdata,  32'h0);
      check("rst_c_valid", ifc.out_tvalid, 1'b0);
      ifa.src_tvalid = '0;
      reset_n        = 1'b1;
      tick();

      // Fixed priority: src0 drains its 3 packets before src1, then src2.
      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < N; i++) begin
            ifa.src_tvalid[i]       = (fx_rem[i] > 0);
            ifa.src_tdata[i*W +: W] = 32'hA000 + 32'(i * 256 + fx_seq[i]);
         end
         #1;
         check("fix_src",   ifa.out_src, 64'(fx_src[s]));
         check("fix_data",  ifa.out_tdata, 64'(32'hA000 + 32'(fx_src[s] * 256 + fx_seq[fx_src[s]])));
         check("fix_ready", ifa.src_tready, 64'(1) << fx_src[s]);
         tick();
         fx_rem[fx_src[s]]--;
         fx_seq[fx_src[s]]++;
      end
      ifa.src_tvalid = '0;
      tick();

      // Lock: 3-beat src2 packet holds the grant against src0.
      ifa.src_tvalid = 3'b100; ifa.src_tlast = 3'b000;
      ifa.src_tdata  = {32'hC0, 32'h0, 32'hD0};
      #1;
      check("lock_b0_src",   ifa.out_src,    2'd2);
      check("lock_b0_ready", ifa.src_tready, 3'b100);
      tick();
      ifa.src_tvalid = 3'b101; ifa.src_tlast = 3'b001;
      ifa.src_tdata[2*W +: W] = 32'hC1;
      #1;
      check("lock_b1_src",   ifa.out_src,    2'd2);
      check("lock_b1_ready", ifa.src_tready, 3'b100);
      tick();
      ifa.src_tlast = 3'b101;
      ifa.src_tdata[2*W +: W] = 32'hC2;
      #1;
      check("lock_b2_src",   ifa.out_src,    2'd2);
      check("lock_b2_last",  ifa.out_tlast,  1'b1);
      check("lock_b2_ready", ifa.src_tready, 3'b100);
      tick();
      ifa.src_tvalid = 3'b001;
      #1;
      check("lock_src0_src",  ifa.out_src,   2'd0);
      check("lock_src0_data", ifa.out_tdata, 32'hD0);
      tick();
      ifa.src_tvalid = '0;
      tick();

      // Round-robin with every source continuously valid.
      ifb.src_tvalid = 3'b111; ifb.src_tlast = 3'b111;
      ifb.src_tdata  = {32'h20, 32'h10, 32'h00};
      for (int s = 0; s < 6; s++) begin
         #1;
         check("rr_src", ifb.out_src, 64'(rr_src[s]));
         tick();
      end
      ifb.src_tvalid = '0;
      tick();

      // Backpressure on the skid stage: two beats absorbed, then ready drops.
      bp_k = 0;
      ifc.src_tlast = 3'b111;
      for (int s = 0; s < 10; s++) begin
         ifc.out_tready        = bp_otr[s];
         ifc.src_tvalid        = {1'b0, bp_sv1[s], 1'b0};
         ifc.src_tdata[W +: W] = 32'hB0 + 32'(bp_k);
         #1;
         check("bp_ready", ifc.src_tready, {1'b0, bp_rdy[s], 1'b0});
         check("bp_valid", ifc.out_tvalid, bp_ov[s]);
         if (bp_ov[s]) begin
            check("bp_data", ifc.out_tdata, 64'(bp_od[s]));
            check("bp_src",  ifc.out_src,   2'd1);
         end
         tick();
         if (bp_rdy[s] && bp_sv1[s]) bp_k++;
      end

      // Reset after the first beat of a multi-beat src1 packet.
      ifc.out_tready = 1'b1;
      ifc.src_tvalid = 3'b010; ifc.src_tlast = 3'b000;
      ifc.src_tdata  = {32'h0, 32'hD0, 32'h0};
      #1;
      check("rstmid_b0_ready", ifc.src_tready, 3'b010);
      tick();
      reset_n        = 1'b0;
      ifc.src_tvalid = '0;
      #1;
      check("rstmid_valid", ifc.out_tvalid, 1'b0);
      check("rstmid_ready", ifc.src_tready, 3'b000);
      tick();
      reset_n        = 1'b1;
      ifc.src_tvalid = 3'b011; ifc.src_tlast = 3'b011;
      ifc.src_tdata  = {32'h0, 32'hD8, 32'hE0};
      #1;
      check("rstmid_post_valid", ifc.out_tvalid, 1'b0);
      check("rstmid_post_ready", ifc.src_tready, 3'b001);
      tick();
      ifc.src_tvalid = 3'b010;
      #1;
      check("rstmid_out_src",  ifc.out_src,   2'd0);
      check("rstmid_out_data", ifc.out_tdata, 32'hE0);
      tick();
      ifc.src_tvalid = '0;
      tick();
      tick();

`ifdef OFS_PLAT_TX_TLP_ARB_STATS_EN
      // src1 is held off for 7 cycles by src0, then sends one packet.
      ifa.src_tlast = 3'b111;
      ifa.src_tdata[W +: W] = 32'h51;
      for (int s = 0; s < 8; s++) begin
         ifa.src_tvalid = {1'b0, 1'b1, (s < 7)};
         ifa.src_tdata[0 +: W] = 32'hF0 + 32'(s);
         tick();
      end
      ifa.src_tvalid = '0;
      check("stats_src1_waits", stats_a[64 +: 32], 32'd7);
      check("stats_src1_pkts",  stats_a[96 +: 32], 32'd1);
      check("stats_src1_max",   maxw_a[16 +: 16],  16'd7);
      check("stats_src0_pkts",  stats_a[32 +: 32], 32'd7);
      tick();
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
